// File: rtl/modular_multiplier_pkg.sv
// Shared types and helpers for the bit-serial modular multiplier.
package modular_multiplier_pkg;

  // Default operand/result width.
  localparam int WIDTH_DEFAULT = 256;

  // Width of the reduction helper. Two guard bits hold 2*acc + addend < 3P.
  // Callers zero-extend into this width, so WIDTH must not exceed WIDTH_DEFAULT.
  localparam int RED_W = WIDTH_DEFAULT + 2;

  // Controller states. The bus also exports the state for observation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_t;

  // Bring t < 3p into [0, p) by subtracting p zero, one or two times.
  function automatic logic [RED_W-1:0] mod_reduce2(input logic [RED_W-1:0] t,
                                                   input logic [RED_W-1:0] p);
    logic [RED_W-1:0] p2;
    p2 = p << 1;
    if (t >= p2) begin
      return t - p2;
    end else if (t >= p) begin
      return t - p;
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/modular_multiplier_if.sv
// Start/done bus of the modular multiplier.
//
// Handshake: the requester holds start high with a and b valid. The
// multiplier samples start only while idle. The cycle after it accepts an
// operation, busy goes high. done pulses for exactly one cycle with product
// and range_err valid. product holds its value until the next result is
// written. A start raised while the block is busy or finishing is ignored.
interface modular_multiplier_if
  import modular_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] product;
  logic             done;
  logic             busy;
  logic             range_err;
  mm_state_t        state;

  modport master (output start, a, b,
                  input  product, done, busy, range_err, state);

  modport slave  (input  start, a, b,
                  output product, done, busy, range_err, state);
endinterface

// File: rtl/modular_multiplier_mod_double_add.sv
// Combinational step of the interleaved multiplier: (2*acc + addend) mod p.
// The step is kept separate so that the point-doubling block can reuse it.
module mod_double_add
  import modular_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] addend_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] res_o
);

  localparam int DW = WIDTH + 2;

  logic [DW-1:0]    t;
  logic [RED_W-1:0] r;

  // acc and addend are both below p, so t is below 3p and needs at most two subtractions.
  always_comb begin
    t     = {1'b0, acc_i, 1'b0} + {2'b00, addend_i};
    r     = mod_reduce2(RED_W'(t), RED_W'(p_i));
    res_o = WIDTH'(r);
  end

endmodule

// File: rtl/modular_multiplier.sv
// Bit-serial interleaved modular multiplier: product = (a * b) mod P.
// It consumes one bit of b per clock, starting with the MSB. The
// controller does a fixed WIDTH steps for every in-range operation.
module modular_multiplier
  import modular_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int P     = 1147
) (
  input  logic                 Clk,
  input  logic                 Reset,
  modular_multiplier_if.slave  bus
);

  localparam int               CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] P_VEC   = WIDTH'(P);
  localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);

  mm_state_t        state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] addend_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] product_q;
  logic             done_q;
  logic             busy_q;
  logic             range_err_q;

  // Each step adds the multiplicand when the current multiplier bit is set.
  always_comb begin
    addend_d = b_q[cnt_q] ? a_q : '0;
  end

  mod_double_add #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .addend_i (addend_d),
    .p_i      (P_VEC),
    .res_o    (acc_d)
  );

  // Controller with registered outputs. busy drops when the controller
  // enters DONE, and done pulses on the following cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            acc_q  <= '0;
            cnt_q  <= CNT_TOP;
            busy_q <= 1'b1;
            if ((bus.a >= P_VEC) || (bus.b >= P_VEC)) begin
              range_err_q <= 1'b1;
              product_q   <= '0;
              state_q     <= DONE;
            end else begin
              range_err_q <= 1'b0;
              state_q     <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.product   = product_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.range_err = range_err_q;
  assign bus.state     = state_q;

endmodule
